// File: rtl/cpu_bus_decoder.sv
// cpu_bus_decoder: address-range decoder with strobe/ack handshake, timeout and sticky error capture
module cpu_bus_decoder #(
   parameter int                                NUM_ENTRIES      = 6,
   parameter int                                ADDR_W           = 16,
   parameter int                                DATA_W           = 32,
   parameter logic [2*ADDR_W*NUM_ENTRIES-1:0]   MODULE_ADDRESSES = {16'h0000, 16'h2800, 16'h8000, 16'h80FC,
                                                                    16'h9000, 16'h900C, 16'h9100, 16'h9110,
                                                                    16'h9200, 16'h9200, 16'h9300, 16'h9300},
   parameter int                                TIMEOUT_CYCLES   = 255,
   parameter logic [DATA_W-1:0]                 UNMAPPED_DATA    = 32'hDEADBEEF
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [ADDR_W-1:0]             address_i,
   input  logic [DATA_W-1:0]             data_i,
   input  logic                          we_i,
   input  logic                          re_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [DATA_W-1:0]             rd_data_o,
   output logic [NUM_ENTRIES-1:0]        mod_sel_o,
   output logic                          mod_we_o,
   output logic [ADDR_W-1:0]             mod_addr_o,
   output logic [DATA_W-1:0]             mod_data_o,
   input  logic [NUM_ENTRIES-1:0]        mod_ack_i,
   input  logic [NUM_ENTRIES*DATA_W-1:0] mod_rd_data_i,
   output logic                          err_o,
   output logic [1:0]                    err_code_o,
   output logic [ADDR_W-1:0]             err_addr_o,
   input  logic                          err_clear_i
);
   localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;
   state_t        state;
   logic [IW-1:0] idx, idx_q;
   logic [CW-1:0] cnt;
   logic          hit, we_q, ack, timeout, err_evt;
   logic [1:0]    err_code_n;
   logic [ADDR_W-1:0] err_addr_n;
   // Descending scan so the lowest matching index is the one left standing
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (address_i >= MODULE_ADDRESSES[(NUM_ENTRIES-i)*2*ADDR_W-1 -: ADDR_W] &&
             address_i <= MODULE_ADDRESSES[(NUM_ENTRIES-i)*2*ADDR_W-ADDR_W-1 -: ADDR_W]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
   end
   assign busy_o     = state != IDLE;
   assign ack        = mod_ack_i[idx_q];
   assign timeout    = cnt == CW'(TIMEOUT_CYCLES - 1);
   assign err_evt    = (state == IDLE && (we_i | re_i) && !hit) || (state == WAIT_ACK && !ack && timeout);
   assign err_code_n = state == IDLE ? 2'd1 : 2'd2;
   assign err_addr_n = state == IDLE ? address_i : mod_addr_o;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         idx_q      <= '0;
         cnt        <= '0;
         we_q       <= 1'b0;
         done_o     <= 1'b0;
         rd_data_o  <= '0;
         mod_sel_o  <= '0;
         mod_we_o   <= 1'b0;
         mod_addr_o <= '0;
         mod_data_o <= '0;
         err_o      <= 1'b0;
         err_code_o <= '0;
         err_addr_o <= '0;
      end else begin
         mod_sel_o <= '0;
         mod_we_o  <= 1'b0;
         done_o    <= 1'b0;
         rd_data_o <= '0;
         // A new error beats a simultaneous clear; otherwise the first error is kept
         if (err_evt && (!err_o || err_clear_i)) begin
            err_o      <= 1'b1;
            err_code_o <= err_code_n;
            err_addr_o <= err_addr_n;
         end else if (err_clear_i) begin
            err_o      <= 1'b0;
            err_code_o <= '0;
            err_addr_o <= '0;
         end
         case (state)
            IDLE: if (we_i | re_i) begin
               mod_addr_o <= address_i;
               mod_data_o <= data_i;
               we_q       <= we_i;
               idx_q      <= idx;
               cnt        <= '0;
               if (hit) begin
                  mod_sel_o <= NUM_ENTRIES'(1) << idx;
                  mod_we_o  <= we_i;
                  state     <= WAIT_ACK;
               end else begin
                  state     <= RESP;
                  done_o    <= 1'b1;
                  rd_data_o <= we_i ? '0 : UNMAPPED_DATA;
               end
            end
            WAIT_ACK: if (ack || timeout) begin
               state     <= RESP;
               done_o    <= 1'b1;
               rd_data_o <= we_q ? '0 : ack ? mod_rd_data_i[idx_q*DATA_W +: DATA_W] : UNMAPPED_DATA;
            end else
               cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
